// File: rtl/eth_phy_pkg.sv
// rtl/eth_phy_pkg.sv - shared types and constants for Ethernet PHY bring-up
package eth_phy_pkg;

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    CFG_REQ,
    CFG_WAIT,
    POLL_IDLE,
    POLL_REQ,
    POLL_WAIT
  } seq_state_t;

  typedef enum logic [1:0] {
    SPEED_10M   = 2'b00,
    SPEED_100M  = 2'b01,
    SPEED_1000M = 2'b10,
    SPEED_RSVD  = 2'b11
  } speed_t;

  localparam int CFG_NUM   = 3;
  localparam int CFG_IDX_W = 2;

  // Config writes issued in order after the PHY leaves hardware reset
  localparam logic [4:0]  CFG_REG  [CFG_NUM] = '{5'h00, 5'h04, 5'h00};
  localparam logic [15:0] CFG_DATA [CFG_NUM] = '{16'h1140, 16'h01E1, 16'h1340};

  localparam logic [4:0] REG_PHY_STATUS = 5'h11;
  localparam int         LINK_BIT       = 10;
  localparam int         SPEED_MSB      = 15;

  // The reserved speed code is reported as 10M
  function automatic speed_t decode_speed(input logic [1:0] code);
    speed_t s;
    s = speed_t'(code);
    return (s == SPEED_RSVD) ? SPEED_10M : s;
  endfunction

endpackage

// File: rtl/phy_cfg_rom.sv
// rtl/phy_cfg_rom.sv - combinational lookup of the PHY config write list
import eth_phy_pkg::*;

module phy_cfg_rom (
  input  logic [CFG_IDX_W-1:0] idx,
  output logic [4:0]           cfg_reg,
  output logic [15:0]          cfg_data
);

  // Select the entry matching idx; out-of-range indices read as zero
  always_comb begin
    cfg_reg  = '0;
    cfg_data = '0;
    for (int i = 0; i < CFG_NUM; i++) begin
      if (idx == CFG_IDX_W'(i)) begin
        cfg_reg  = CFG_REG[i];
        cfg_data = CFG_DATA[i];
      end
    end
  end

endmodule

// File: rtl/phy_bringup_seq.sv
// rtl/phy_bringup_seq.sv - PHY reset, MDIO config list and periodic status poll
import eth_phy_pkg::*;

module phy_bringup_seq #(
  parameter int unsigned RSTN_LOW_CYC  = 1_000_000,
  parameter int unsigned RSTN_WAIT_CYC = 6_000_000,
  parameter int unsigned POLL_CYC      = 5_000_000,
  parameter int unsigned ACK_TIMEOUT   = 65_535,
  parameter logic [4:0]  PHY_ADDR      = 5'd0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_restart,
  output logic        o_phy_rst_n,
  output logic        o_mdio_req,
  output logic        o_mdio_wr,
  output logic [4:0]  o_mdio_phy,
  output logic [4:0]  o_mdio_reg,
  output logic [15:0] o_mdio_wdata,
  input  logic        i_mdio_ack,
  input  logic [15:0] i_mdio_rdata,
  output logic        o_cfg_done,
  output logic        o_link_up,
  output logic [1:0]  o_speed,
  output logic        o_err
);

  localparam logic [31:0] LOW_LAST  = 32'(RSTN_LOW_CYC - 1);
  localparam logic [31:0] WAIT_LAST = 32'(RSTN_WAIT_CYC - 1);
  localparam logic [31:0] POLL_LAST = 32'(POLL_CYC - 1);
  localparam logic [31:0] TO_LAST   = 32'(ACK_TIMEOUT - 1);
  localparam logic [CFG_IDX_W-1:0] IDX_LAST = CFG_IDX_W'(CFG_NUM - 1);

  seq_state_t           state;
  logic [31:0]          cnt;
  logic [CFG_IDX_W-1:0] idx;
  logic [4:0]           rom_reg;
  logic [15:0]          rom_data;
  logic                 ack_ok;
  logic                 rdata_unused;

  phy_cfg_rom u_cfg_rom (
    .idx      (idx),
    .cfg_reg  (rom_reg),
    .cfg_data (rom_data)
  );

  assign o_mdio_phy = PHY_ADDR;

  // An ack only counts against an outstanding request; stray pulses are dropped
  assign ack_ok = i_mdio_ack & o_mdio_req;

  // Only the link and speed fields of the status word are consumed
  assign rdata_unused = ^i_mdio_rdata;

  // Bring-up sequencer: one shared wait counter, cleared on every state change
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= RST_LOW;
      cnt          <= '0;
      idx          <= '0;
      o_phy_rst_n  <= 1'b0;
      o_mdio_req   <= 1'b0;
      o_mdio_wr    <= 1'b0;
      o_mdio_reg   <= '0;
      o_mdio_wdata <= '0;
      o_cfg_done   <= 1'b0;
      o_link_up    <= 1'b0;
      o_speed      <= SPEED_10M;
      o_err        <= 1'b0;
    end else if (i_restart) begin
      // Error flag survives a restart so software can still see it
      state       <= RST_LOW;
      cnt         <= '0;
      o_phy_rst_n <= 1'b0;
      o_mdio_req  <= 1'b0;
      o_cfg_done  <= 1'b0;
      o_link_up   <= 1'b0;
      o_speed     <= SPEED_10M;
    end else begin
      cnt <= cnt + 32'd1;
      case (state)
        RST_LOW: begin
          if (cnt == LOW_LAST) begin
            state       <= RST_WAIT;
            cnt         <= '0;
            o_phy_rst_n <= 1'b1;
          end
        end
        RST_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state <= CFG_REQ;
            cnt   <= '0;
            idx   <= '0;
          end
        end
        CFG_REQ: begin
          state        <= CFG_WAIT;
          cnt          <= '0;
          o_mdio_req   <= 1'b1;
          o_mdio_wr    <= 1'b1;
          o_mdio_reg   <= rom_reg;
          o_mdio_wdata <= rom_data;
        end
        CFG_WAIT: begin
          if (ack_ok) begin
            cnt        <= '0;
            o_mdio_req <= 1'b0;
            if (idx == IDX_LAST) begin
              state      <= POLL_IDLE;
              o_cfg_done <= 1'b1;
            end else begin
              state <= CFG_REQ;
              idx   <= idx + CFG_IDX_W'(1);
            end
          end else if (cnt == TO_LAST) begin
            // A silent PHY during config gets a full hardware reset retry
            state       <= RST_LOW;
            cnt         <= '0;
            o_mdio_req  <= 1'b0;
            o_phy_rst_n <= 1'b0;
            o_err       <= 1'b1;
            o_link_up   <= 1'b0;
          end
        end
        POLL_IDLE: begin
          if (cnt == POLL_LAST) begin
            state <= POLL_REQ;
            cnt   <= '0;
          end
        end
        POLL_REQ: begin
          state      <= POLL_WAIT;
          cnt        <= '0;
          o_mdio_req <= 1'b1;
          o_mdio_wr  <= 1'b0;
          o_mdio_reg <= REG_PHY_STATUS;
        end
        POLL_WAIT: begin
          if (ack_ok) begin
            state      <= POLL_IDLE;
            cnt        <= '0;
            o_mdio_req <= 1'b0;
            o_link_up  <= i_mdio_rdata[LINK_BIT];
            o_speed    <= decode_speed(i_mdio_rdata[SPEED_MSB -: 2]);
          end else if (cnt == TO_LAST) begin
            state      <= POLL_IDLE;
            cnt        <= '0;
            o_mdio_req <= 1'b0;
            o_err      <= 1'b1;
            o_link_up  <= 1'b0;
          end
        end
        default: begin
          state <= RST_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
